// File: rtl/tdm_osc_bank.sv
// tdm_osc_bank: time-multiplexed bank of NUM_OSCS audio oscillators.
// A single counter/phase datapath visits one channel per clock (slot) and
// accumulates the per-channel waveforms into an unsigned mix once per sample.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   cfg_we         config write strobe
//   cfg_be         byte enables for cfg_wdata[7:0] / [15:8]
//   cfg_addr       target oscillator of the config write
//   cfg_wdata      config word {mode[1:0], sync, octave, mantissa}
//   slot           oscillator processed this cycle
//   sample_strobe  one-cycle pulse when audio_out updates
//   audio_out      unsigned mix, left-aligned to OUT_BITS
//   osc_trig       per-channel "phase stepped during last sample" flags
module tdm_osc_bank #(
    parameter int unsigned NUM_OSCS     = 4,
    parameter int unsigned OCT_BITS     = 4,
    parameter int unsigned PERIOD_BITS  = 10,
    parameter int unsigned WAVE_BITS    = 4,
    parameter int unsigned DIVIDER_BITS = 16,
    parameter int unsigned OUT_BITS     = 8,
    localparam int unsigned SLOT_BITS   = $clog2(NUM_OSCS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_be,
    input  logic [SLOT_BITS-1:0] cfg_addr,
    input  logic [15:0]          cfg_wdata,
    output logic [SLOT_BITS-1:0] slot,
    output logic                 sample_strobe,
    output logic [OUT_BITS-1:0]  audio_out,
    output logic [NUM_OSCS-1:0]  osc_trig
);

    localparam int unsigned MIX_BITS = WAVE_BITS + SLOT_BITS;
    localparam int unsigned NUM_OCT  = 2 ** OCT_BITS;

    localparam logic [SLOT_BITS-1:0] LAST_SLOT  = SLOT_BITS'(NUM_OSCS - 1);
    localparam logic [OCT_BITS-1:0]  FREEZE_OCT = '1;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_SAW   = 2'b01;
    localparam logic [1:0] MODE_PULSE = 2'b10;
    localparam logic [1:0] MODE_TRI   = 2'b11;

    // Per-channel state
    logic [15:0]            cfg     [NUM_OSCS];
    logic [PERIOD_BITS-1:0] counter [NUM_OSCS];
    logic [WAVE_BITS-1:0]   phase   [NUM_OSCS];

    logic [DIVIDER_BITS-1:0] divider;
    logic [MIX_BITS-1:0]     acc;
    logic                    trig_prev;
    logic [NUM_OSCS-1:0]     trig_seen;

    // Decoded view of the channel in the current slot
    logic [15:0]            cur_cfg;
    logic [1:0]             cur_mode;
    logic                   cur_sync;
    logic [OCT_BITS-1:0]    cur_oct;
    logic [PERIOD_BITS-1:0] cur_period;
    logic [PERIOD_BITS-1:0] cur_cnt;
    logic [WAVE_BITS-1:0]   cur_ph;

    logic                   chan_active;
    logic                   chan_en;
    logic                   do_sync;
    logic                   step;
    logic                   trigger;
    logic [PERIOD_BITS-1:0] next_cnt;
    logic [WAVE_BITS-1:0]   next_ph;
    logic [WAVE_BITS-1:0]   wave;
    logic [MIX_BITS-1:0]    acc_base;
    logic [MIX_BITS-1:0]    mix;
    logic [MIX_BITS+OUT_BITS-1:0] mix_wide;
    logic [NUM_OSCS-1:0]    trig_next;
    logic [SLOT_BITS-1:0]   slot_next;
    logic [NUM_OCT-1:0]     oct_en;

    // Octave k fires when bit k-1 of the divider rises on the next increment,
    // i.e. the low k bits currently read 0111..1.
    assign oct_en[0]         = 1'b1;
    assign oct_en[NUM_OCT-1] = 1'b0;
    for (genvar k = 1; k < NUM_OCT - 1; k++) begin : g_oct_en
        assign oct_en[k] = (divider[k-1:0] == (k)'((1 << (k - 1)) - 1));
    end

    // Channel decode and counter/phase update for the current slot
    always_comb begin
        cur_cfg    = cfg[slot];
        cur_mode   = cur_cfg[15:14];
        cur_sync   = cur_cfg[13];
        cur_oct    = cur_cfg[OCT_BITS+PERIOD_BITS-2 -: OCT_BITS];
        cur_period = {1'b1, cur_cfg[PERIOD_BITS-2:0]};
        cur_cnt    = counter[slot];
        cur_ph     = phase[slot];

        chan_active = (cur_mode != MODE_OFF);
        chan_en     = chan_active && (cur_oct != FREEZE_OCT) && oct_en[cur_oct];
        do_sync     = chan_active && cur_sync && trig_prev;
        step        = chan_en && (cur_cnt == '0);
        trigger     = step && !do_sync;

        next_cnt = cur_cnt;
        next_ph  = cur_ph;
        if (!chan_active) begin
            next_cnt = '0;
            next_ph  = '0;
        end else if (do_sync) begin
            next_cnt = cur_period - PERIOD_BITS'(1);
            next_ph  = '0;
        end else if (chan_en) begin
            next_cnt = step ? (cur_period - PERIOD_BITS'(1)) : (cur_cnt - PERIOD_BITS'(1));
            next_ph  = cur_ph + WAVE_BITS'(step);
        end
    end

    // Waveform from the pre-update phase
    always_comb begin
        wave = '0;
        case (cur_mode)
            MODE_SAW:   wave = cur_ph;
            MODE_PULSE: wave = {WAVE_BITS{cur_ph[WAVE_BITS-1]}};
            MODE_TRI:   wave = cur_ph[WAVE_BITS-1] ? ~{cur_ph[WAVE_BITS-2:0], 1'b0}
                                                   :  {cur_ph[WAVE_BITS-2:0], 1'b0};
            default:    wave = '0;
        endcase
    end

    // Mix accumulation, trigger collection and slot sequencing
    always_comb begin
        acc_base  = (slot == '0) ? '0 : acc;
        mix       = acc_base + MIX_BITS'(wave);
        mix_wide  = {mix, {OUT_BITS{1'b0}}};
        trig_next = trig_seen;
        trig_next[slot] = trigger;
        slot_next = (slot == LAST_SLOT) ? '0 : (slot + SLOT_BITS'(1));
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < NUM_OSCS; j++) begin
                cfg[j]     <= '0;
                counter[j] <= '0;
                phase[j]   <= '0;
            end
            slot          <= '0;
            divider       <= '0;
            acc           <= '0;
            trig_prev     <= 1'b0;
            trig_seen     <= '0;
            audio_out     <= '0;
            sample_strobe <= 1'b0;
            osc_trig      <= '0;
        end else begin
            slot          <= slot_next;
            counter[slot] <= next_cnt;
            phase[slot]   <= next_ph;
            trig_prev     <= trigger;
            trig_seen     <= trig_next;
            acc           <= mix;
            sample_strobe <= (slot == LAST_SLOT);
            if (slot == LAST_SLOT) begin
                audio_out <= mix_wide[MIX_BITS+OUT_BITS-1 -: OUT_BITS];
                divider   <= divider + DIVIDER_BITS'(1);
                osc_trig  <= trig_next;
            end
            // Addresses beyond NUM_OSCS-1 match no channel and are dropped
            for (int j = 0; j < NUM_OSCS; j++) begin
                if (cfg_we && (cfg_addr == SLOT_BITS'(j))) begin
                    if (cfg_be[0]) cfg[j][7:0]  <= cfg_wdata[7:0];
                    if (cfg_be[1]) cfg[j][15:8] <= cfg_wdata[15:8];
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_osc_bank.sv
// Self-checking bench for tdm_osc_bank: directed scenarios plus random config
// writes, compared every cycle against a sample-level arithmetic model.
module tb_tdm_osc_bank;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [1:0] cfg_be;
    logic [1:0] cfg_addr;
    logic [15:0] cfg_wdata;
    logic [1:0] slot;
    logic       sample_strobe;
    logic [7:0] audio_out;
    logic [3:0] osc_trig;

    tdm_osc_bank #(
        .NUM_OSCS(4), .OCT_BITS(4), .PERIOD_BITS(10),
        .WAVE_BITS(4), .DIVIDER_BITS(16), .OUT_BITS(8)
    ) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_be(cfg_be),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .slot(slot),
        .sample_strobe(sample_strobe), .audio_out(audio_out), .osc_trig(osc_trig)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [15:0] m_cfg [N];
    int          m_cnt [N];
    int          m_ph  [N];
    int          m_slot, m_div, m_acc;
    bit          m_tprev;
    bit [N-1:0]  m_tseen;
    int          e_audio;
    bit          e_strobe;
    bit [N-1:0]  e_otrig;

    function automatic int wave_of(input int mode, input int ph);
        case (mode)
            1:       return ph;
            2:       return (ph >= 8) ? 15 : 0;
            3:       return (ph < 8) ? 2 * ph : 15 - 2 * (ph - 8);
            default: return 0;
        endcase
    endfunction

    // Advance the model by one clock using the inputs present before the edge
    task automatic model_step();
        int c, mode, oct, per, wv, sum;
        bit sync, octave_tick, trig;
        logic [15:0] w;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_cfg[i] = '0; m_cnt[i] = 0; m_ph[i] = 0;
            end
            m_slot = 0; m_div = 0; m_acc = 0; m_tprev = 0; m_tseen = '0;
            e_audio = 0; e_strobe = 0; e_otrig = '0;
        end else begin
            c    = m_slot;
            w    = m_cfg[c];
            mode = int'(w[15:14]);
            sync = w[13];
            oct  = int'(w[12:9]);
            per  = 512 + int'(w[8:0]);
            octave_tick = (oct != 15) &&
                          (oct == 0 || (m_div % (1 << oct)) == (1 << (oct - 1)) - 1);
            wv   = wave_of(mode, m_ph[c]);
            trig = 0;
            if (mode == 0) begin
                m_cnt[c] = 0; m_ph[c] = 0;
            end else if (sync && m_tprev) begin
                m_cnt[c] = per - 1; m_ph[c] = 0;
            end else if (octave_tick) begin
                if (m_cnt[c] == 0) begin
                    trig = 1; m_cnt[c] = per - 1; m_ph[c] = (m_ph[c] + 1) % 16;
                end else begin
                    m_cnt[c] = m_cnt[c] - 1;
                end
            end
            sum        = ((c == 0) ? 0 : m_acc) + wv;
            m_acc      = sum;
            m_tseen[c] = trig;
            m_tprev    = trig;
            e_strobe   = (c == N - 1);
            if (c == N - 1) begin
                e_audio = (sum * 4) % 256;
                e_otrig = m_tseen;
                m_div   = (m_div + 1) % 65536;
            end
            m_slot = (c + 1) % N;
            if (cfg_we) begin
                if (cfg_be[0]) m_cfg[cfg_addr][7:0]  = cfg_wdata[7:0];
                if (cfg_be[1]) m_cfg[cfg_addr][15:8] = cfg_wdata[15:8];
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("slot", 32'(slot), 32'(m_slot));
        check("sample_strobe", 32'(sample_strobe), 32'(e_strobe));
        check("audio_out", 32'(audio_out), 32'(e_audio));
        check("osc_trig", 32'(osc_trig), 32'(e_otrig));
    endtask

    task automatic write_cfg(input logic [1:0] addr, input logic [1:0] be, input logic [15:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_be = be; cfg_wdata = data;
        tick();
        cfg_we = 1'b0; cfg_be = 2'b00;
    endtask

    task automatic wait_slot(input int s);
        for (int i = 0; i < N && m_slot != s; i++) tick();
    endtask

    initial begin
        logic [1:0] r_mode;
        logic       r_sync;
        logic [3:0] r_oct;
        logic [8:0] r_mant;
        reset = 1'b1; cfg_we = 1'b0; cfg_be = 2'b00; cfg_addr = 2'd0; cfg_wdata = 16'h0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_slot", 32'(slot), 32'd0);
        check("rst_audio", 32'(audio_out), 32'd0);
        check("rst_strobe", 32'(sample_strobe), 32'd0);
        repeat (16) tick();
        check("idle_audio", 32'(audio_out), 32'd0);
        check("idle_trig", 32'(osc_trig), 32'd0);

        // Saw on osc0, period 512: first step in the next sample, 0x04 one sample later
        wait_slot(0);
        write_cfg(2'd0, 2'b11, 16'h4000);
        repeat (7) tick();
        check("saw_first_trig", 32'(osc_trig), 32'h1);
        check("saw_first_audio", 32'(audio_out), 32'h00);
        repeat (4) tick();
        check("saw_step1_audio", 32'(audio_out), 32'h04);
        repeat (4 * 1100) tick();

        // Pulse on osc1 and triangle on osc2
        write_cfg(2'd1, 2'b11, 16'h8000);
        write_cfg(2'd2, 2'b11, 16'hC000);
        repeat (4 * 4700) tick();

        // Hard sync of osc1 to osc0, half-rate octave on osc2, frozen osc3
        write_cfg(2'd1, 2'b11, 16'h61FF);
        write_cfg(2'd2, 2'b11, 16'h4200);
        write_cfg(2'd3, 2'b11, 16'h5E00);
        repeat (4 * 2300) tick();

        // Low-byte write to the channel being processed
        wait_slot(0);
        write_cfg(2'd0, 2'b01, 16'hFF05);
        repeat (4 * 600) tick();

        // Random config traffic
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                r_mode = 2'($urandom_range(0, 3));
                r_sync = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 4))
                    0: r_oct = 4'd0;
                    1: r_oct = 4'd1;
                    2: r_oct = 4'd2;
                    3: r_oct = 4'd15;
                    default: r_oct = 4'($urandom_range(0, 15));
                endcase
                r_mant = 9'($urandom_range(0, 511));
                write_cfg(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          {r_mode, r_sync, r_oct, r_mant});
            end else begin
                tick();
            end
        end

        // Reset in the middle of a sample
        wait_slot(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_slot", 32'(slot), 32'd0);
        check("midrst_audio", 32'(audio_out), 32'd0);
        check("midrst_strobe", 32'(sample_strobe), 32'd0);
        check("midrst_trig", 32'(osc_trig), 32'd0);
        write_cfg(2'd0, 2'b11, 16'h4000);
        repeat (11) tick();
        check("midrst_saw_audio", 32'(audio_out), 32'h04);
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
